// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer, ALU and datapath:
// opcodes, ALU operation encodings, sequencer states and instruction fields.
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    localparam logic [2:0] ALUOP_FWD = 3'b000;
    localparam logic [2:0] ALUOP_ADD = 3'b001;
    localparam logic [2:0] ALUOP_OR  = 3'b010;
    localparam logic [2:0] ALUOP_AND = 3'b011;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2
    } state_e;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 24;
    localparam int unsigned DEST_MSB   = 23;
    localparam int unsigned DEST_LSB   = 16;
    localparam int unsigned SRC1_MSB   = 15;
    localparam int unsigned SRC1_LSB   = 8;
    localparam int unsigned SRC2_MSB   = 7;
    localparam int unsigned SRC2_LSB   = 0;

    // Branch target: word offset relative to the following instruction, mod 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [7:0]  offset);
        branch_target = pc + 32'd4 + {{22{offset[7]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Purely combinational opcode decode into ALU controls and instruction class flags.
module instruction_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] opcode_i,
    output logic [2:0] alu_op_o,
    output logic       imm_sel_o,
    output logic       neg_sel_o,
    output logic       is_write_o,
    output logic       is_jump_o,
    output logic       is_beq_o,
    output logic       is_illegal_o
);

    // Opcode to control mapping; anything undefined is treated as illegal.
    always_comb begin
        alu_op_o     = ALUOP_FWD;
        imm_sel_o    = 1'b0;
        neg_sel_o    = 1'b0;
        is_write_o   = 1'b0;
        is_jump_o    = 1'b0;
        is_beq_o     = 1'b0;
        is_illegal_o = 1'b0;
        case (opcode_i)
            OP_LOADI: begin
                imm_sel_o  = 1'b1;
                is_write_o = 1'b1;
            end
            OP_MOV: begin
                is_write_o = 1'b1;
            end
            OP_ADD: begin
                alu_op_o   = ALUOP_ADD;
                is_write_o = 1'b1;
            end
            OP_SUB: begin
                alu_op_o   = ALUOP_ADD;
                neg_sel_o  = 1'b1;
                is_write_o = 1'b1;
            end
            OP_AND: begin
                alu_op_o   = ALUOP_AND;
                is_write_o = 1'b1;
            end
            OP_OR: begin
                alu_op_o   = ALUOP_OR;
                is_write_o = 1'b1;
            end
            OP_J: begin
                is_jump_o = 1'b1;
            end
            OP_BEQ: begin
                alu_op_o  = ALUOP_ADD;
                neg_sel_o = 1'b1;
                is_beq_o  = 1'b1;
            end
            default: begin
                is_illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Three-state fetch/execute/write-back sequencer driving the ALU and register file,
// holding the instruction register and program counter.
module cpu_control_unit
    import cpu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTR,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    input  logic        COMPARATOR,
    output logic [2:0]  ALU_OP,
    output logic        IMM_SEL,
    output logic        NEG_SEL,
    output logic [7:0]  IMMEDIATE,
    output logic [2:0]  READ_ADDR1,
    output logic [2:0]  READ_ADDR2,
    output logic [2:0]  WRITE_ADDR,
    output logic        REG_WRITE,
    output logic [31:0] PC,
    output logic        ILLEGAL
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_q, pc_d;
    logic        ready_q, ready_d;
    logic        reg_write_q, reg_write_d;
    logic        illegal_q, illegal_d;

    logic        is_write_s;
    logic        is_jump_s;
    logic        is_beq_s;
    logic        is_illegal_s;
    logic [31:0] target_s;
    logic        unused_ir_bits_s;

    instruction_decoder u_decoder (
        .opcode_i     (ir_q[OPCODE_MSB:OPCODE_LSB]),
        .alu_op_o     (ALU_OP),
        .imm_sel_o    (IMM_SEL),
        .neg_sel_o    (NEG_SEL),
        .is_write_o   (is_write_s),
        .is_jump_o    (is_jump_s),
        .is_beq_o     (is_beq_s),
        .is_illegal_o (is_illegal_s)
    );

    assign target_s         = branch_target(pc_q, ir_q[DEST_MSB:DEST_LSB]);
    assign unused_ir_bits_s = ^ir_q[SRC1_MSB:SRC1_LSB+3];

    assign IMMEDIATE   = ir_q[SRC2_MSB:SRC2_LSB];
    assign READ_ADDR1  = ir_q[SRC1_LSB+2:SRC1_LSB];
    assign READ_ADDR2  = ir_q[SRC2_LSB+2:SRC2_LSB];
    assign WRITE_ADDR  = ir_q[DEST_LSB+2:DEST_LSB];
    assign INSTR_READY = ready_q;
    assign REG_WRITE   = reg_write_q;
    assign ILLEGAL     = illegal_q;
    assign PC          = pc_q;

    // Next-state logic; write/illegal pulses are staged in EXEC so they are registered in WB.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        reg_write_d = 1'b0;
        illegal_d   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (INSTR_VALID) begin
                    ir_d    = INSTR;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                state_d     = S_WB;
                reg_write_d = is_write_s;
                illegal_d   = is_illegal_s;
            end
            S_WB: begin
                state_d = S_FETCH;
                if (is_jump_s || (is_beq_s && COMPARATOR)) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        ready_d = (state_d == S_FETCH);
    end

    // State, instruction, PC and registered control outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_FETCH;
            ir_q        <= 32'h0000_0000;
            pc_q        <= 32'h0000_0000;
            ready_q     <= 1'b1;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            ready_q     <= ready_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed vector table, corner sequences,
// and random instructions checked against an opcode-table reference model.
module tb_cpu_control_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic        COMPARATOR;
    logic [2:0]  ALU_OP;
    logic        IMM_SEL;
    logic        NEG_SEL;
    logic [7:0]  IMMEDIATE;
    logic [2:0]  READ_ADDR1;
    logic [2:0]  READ_ADDR2;
    logic [2:0]  WRITE_ADDR;
    logic        REG_WRITE;
    logic [31:0] PC;
    logic        ILLEGAL;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_control_unit dut (
        .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .COMPARATOR(COMPARATOR), .ALU_OP(ALU_OP),
        .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL), .IMMEDIATE(IMMEDIATE),
        .READ_ADDR1(READ_ADDR1), .READ_ADDR2(READ_ADDR2), .WRITE_ADDR(WRITE_ADDR),
        .REG_WRITE(REG_WRITE), .PC(PC), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic        cmp;
        logic [2:0]  alu;
        logic        imm;
        logic        neg;
        logic        wr;
        logic        ill;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[12];

    // Reference tables indexed by opcode 0..7 (loadi, mov, add, sub, and, or, j, beq).
    logic [2:0] ref_alu[8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd3, 3'd2, 3'd0, 3'd1};
    logic       ref_imm[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ref_neg[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ref_wr [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    logic [31:0] exp_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full accept/EXEC/WB/FETCH pass with checks at each step.
    task automatic run_instr(input logic [31:0] instr, input logic cmp,
                             input logic [2:0] e_alu, input logic e_imm, input logic e_neg,
                             input logic e_wr, input logic e_ill, input logic [31:0] e_pc);
        logic care;
        care = (instr[31:24] != 8'h06);
        @(negedge CLK);
        chk("ready_before_accept", {31'd0, INSTR_READY}, 32'd1);
        INSTR       = instr;
        INSTR_VALID = 1'b1;
        COMPARATOR  = ~cmp;
        @(posedge CLK); #1;
        INSTR_VALID = 1'b0;
        INSTR       = $urandom;
        chk("ready_exec", {31'd0, INSTR_READY}, 32'd0);
        if (care) begin
            chk("alu_op", {29'd0, ALU_OP}, {29'd0, e_alu});
            chk("imm_sel", {31'd0, IMM_SEL}, {31'd0, e_imm});
            chk("neg_sel", {31'd0, NEG_SEL}, {31'd0, e_neg});
        end
        chk("immediate", {24'd0, IMMEDIATE}, {24'd0, instr[7:0]});
        chk("read_addr1", {29'd0, READ_ADDR1}, {29'd0, instr[10:8]});
        chk("read_addr2", {29'd0, READ_ADDR2}, {29'd0, instr[2:0]});
        chk("write_addr", {29'd0, WRITE_ADDR}, {29'd0, instr[18:16]});
        chk("reg_write_exec", {31'd0, REG_WRITE}, 32'd0);
        chk("illegal_exec", {31'd0, ILLEGAL}, 32'd0);
        @(posedge CLK); #1;
        COMPARATOR = cmp;
        chk("ready_wb", {31'd0, INSTR_READY}, 32'd0);
        chk("reg_write_wb", {31'd0, REG_WRITE}, {31'd0, e_wr});
        chk("illegal_wb", {31'd0, ILLEGAL}, {31'd0, e_ill});
        chk("immediate_wb", {24'd0, IMMEDIATE}, {24'd0, instr[7:0]});
        @(posedge CLK); #1;
        COMPARATOR = ~cmp;
        chk("pc", PC, e_pc);
        chk("ready_after", {31'd0, INSTR_READY}, 32'd1);
        chk("reg_write_after", {31'd0, REG_WRITE}, 32'd0);
        chk("illegal_after", {31'd0, ILLEGAL}, 32'd0);
        if (care) chk("alu_op_hold", {29'd0, ALU_OP}, {29'd0, e_alu});
    endtask

    // Reference model: opcode tables plus branch arithmetic on integers.
    task automatic model_run(input logic [31:0] instr, input logic cmp);
        logic [7:0]  op;
        logic [31:0] nxt;
        int          off;
        op  = instr[31:24];
        off = $signed(instr[23:16]) * 4;
        if (op == 8'd6 || (op == 8'd7 && cmp)) nxt = exp_pc + 32'd4 + off;
        else                                   nxt = exp_pc + 32'd4;
        if (op < 8'd8)
            run_instr(instr, cmp, ref_alu[op[2:0]], ref_imm[op[2:0]], ref_neg[op[2:0]],
                      ref_wr[op[2:0]], 1'b0, nxt);
        else
            run_instr(instr, cmp, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, nxt);
        exp_pc = nxt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{32'h0005_002A, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0004};
        vecs[1]  = '{32'h0302_0103, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0008};
        vecs[2]  = '{32'h07FE_0102, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0004};
        vecs[3]  = '{32'h0302_0103, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0008};
        vecs[4]  = '{32'h07FE_0102, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_000C};
        vecs[5]  = '{32'h06F8_0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0};
        vecs[6]  = '{32'h067F_0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_01F0};
        vecs[7]  = '{32'hFF12_3456, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_01F4};
        vecs[8]  = '{32'h0403_0201, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_01F8};
        vecs[9]  = '{32'h0507_0605, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_01FC};
        vecs[10] = '{32'h0101_0200, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200};
        vecs[11] = '{32'h0204_0506, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0204};

        RESET       = 1'b0;
        INSTR       = 32'h0204_0506;
        INSTR_VALID = 1'b1;
        COMPARATOR  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", {31'd0, INSTR_READY}, 32'd1);
        chk("rst_pc", PC, 32'd0);
        chk("rst_alu_op", {29'd0, ALU_OP}, 32'd0);
        chk("rst_imm_sel", {31'd0, IMM_SEL}, 32'd1);
        chk("rst_write_addr", {29'd0, WRITE_ADDR}, 32'd0);
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        RESET       = 1'b1;
        @(posedge CLK); #1;
        chk("post_rst_pc", PC, 32'd0);
        chk("post_rst_reg_write", {31'd0, REG_WRITE}, 32'd0);
        chk("post_rst_ready", {31'd0, INSTR_READY}, 32'd1);

        for (int i = 0; i < 12; i++)
            run_instr(vecs[i].instr, vecs[i].cmp, vecs[i].alu, vecs[i].imm, vecs[i].neg,
                      vecs[i].wr, vecs[i].ill, vecs[i].pc);
        exp_pc = 32'h0000_0204;

        // Back-pressure: nothing offered for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            chk("idle_ready", {31'd0, INSTR_READY}, 32'd1);
            chk("idle_pc", PC, exp_pc);
            chk("idle_reg_write", {31'd0, REG_WRITE}, 32'd0);
        end

        // Reset during EXEC of an add: instruction discarded.
        @(negedge CLK);
        INSTR       = 32'h0203_0102;
        INSTR_VALID = 1'b1;
        @(posedge CLK); #1;
        INSTR_VALID = 1'b0;
        chk("mid_exec_ready", {31'd0, INSTR_READY}, 32'd0);
        RESET = 1'b0;
        #1;
        chk("mid_rst_pc", PC, 32'd0);
        chk("mid_rst_ready", {31'd0, INSTR_READY}, 32'd1);
        chk("mid_rst_imm_sel", {31'd0, IMM_SEL}, 32'd1);
        chk("mid_rst_alu_op", {29'd0, ALU_OP}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            chk("mid_rst_reg_write", {31'd0, REG_WRITE}, 32'd0);
        end
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("mid_rst_reg_write_rel", {31'd0, REG_WRITE}, 32'd0);
        exp_pc = 32'd0;
        model_run(32'h0203_0102, 1'b0);

        // Random instructions against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 4) != 0) w[31:24] = 8'($urandom_range(0, 7));
            model_run(w, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
